// File: rtl/wb_master_bridge_pkg.sv
// Shared types and constants for the Wishbone master bridge.
// Also holds harness register addresses for bench/firmware reuse.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_ADR_W-1:0] ADDR_ACTIVE = 32'h00FF_00FF;
  localparam logic [WB_ADR_W-1:0] ADDR_WS2812 = 32'h00FF_00FA;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } wb_state_e;

  typedef struct packed {
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_master_bridge_if.sv
// Command/response handshake plus Wishbone initiator bus.
// master = bridge view, slave = host and harness view.
interface wb_master_bridge_if;
  import wb_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [WB_SEL_W-1:0] cmd_sel;
  logic [WB_ADR_W-1:0] cmd_addr;
  logic [WB_DAT_W-1:0] cmd_wdata;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WB_DAT_W-1:0] rsp_rdata;
  logic                rsp_err;

  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [WB_SEL_W-1:0] wbm_sel_o;
  logic [WB_ADR_W-1:0] wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_o;
  logic                wbm_ack_i;
  logic [WB_DAT_W-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel,
    input  cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel,
    output cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );

endinterface

// File: rtl/wb_master_bridge_timeout.sv
// Saturating 8-bit bus-wait counter for the bridge.
// expired_o is high while the count sits at TIMEOUT_CYCLES-1.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LAST =
    8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator driven by a
// valid/ready command port, with bounded wait on ack.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [WB_DAT_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic                wb_clk_i,
  input logic                wb_rst_ni,
  wb_master_bridge_if.master bus_if
);

  wb_state_e           state_q;
  wb_req_t             req_q;
  logic                cyc_q;
  logic                stb_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [WB_DAT_W-1:0] rsp_rdata_q;

  logic accept;
  logic tmo_en;
  logic expired;

  assign accept = (state_q == IDLE) && bus_if.cmd_valid;
  assign tmo_en = (state_q == BUS) && !bus_if.wbm_ack_i;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .clear_i  (accept),
    .enable_i (tmo_en),
    .expired_o(expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus_if.cmd_valid) begin
            req_q <= '{
              we:  bus_if.cmd_we,
              sel: bus_if.cmd_sel,
              adr: bus_if.cmd_addr,
              dat: bus_if.cmd_wdata
            };
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          // ack beats a coincident timeout
          if (bus_if.wbm_ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= req_q.we ? '0
                         : bus_if.wbm_dat_i;
            state_q     <= RESP;
          end else if (expired) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= req_q.we ? '0 : ERR_DATA;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.cmd_ready = (state_q == IDLE);
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_err   = rsp_err_q;
  assign bus_if.rsp_rdata = rsp_rdata_q;
  assign bus_if.wbm_cyc_o = cyc_q;
  assign bus_if.wbm_stb_o = stb_q;
  assign bus_if.wbm_we_o  = req_q.we;
  assign bus_if.wbm_sel_o = req_q.sel;
  assign bus_if.wbm_adr_o = req_q.adr;
  assign bus_if.wbm_dat_o = req_q.dat;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: harness-like slave, delayed-ack
// slave and an abstract register-map reference model.
module tb_wb_master_bridge;
  import wb_pkg::*;

  localparam int TO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [31:0] DLY_DATA = 32'h1234_5678;
  localparam logic [31:0] UNMAPPED = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_master_bridge_if bif();

  wb_master_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA(ERR)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus_if   (bif)
  );

  int tests = 0;
  int fails = 0;

  // slave environment: mode 0 = harness, mode 1 = ack after dly
  int mode = 0;
  int dly = 0;
  int bcnt = 0;
  int n_cyc = 0;
  int n_ack = 0;
  logic ack_q = 1'b0;
  logic ack_force = 1'b0;
  logic [31:0] sdat_q = '0;
  logic [31:0] hmem [2] = '{32'h0, 32'h0};

  function automatic int hidx(input logic [31:0] a);
    if (a == ADDR_ACTIVE) return 0;
    if (a == ADDR_WS2812) return 1;
    return -1;
  endfunction

  assign bif.wbm_ack_i = ack_q | ack_force;
  assign bif.wbm_dat_i = sdat_q;

  always @(posedge clk) begin
    automatic logic req;
    automatic int ix;
    req = bif.wbm_cyc_o && bif.wbm_stb_o;
    ix = hidx(bif.wbm_adr_o);
    bcnt <= bif.wbm_cyc_o ? bcnt + 1 : 0;
    if (bif.wbm_cyc_o) n_cyc <= n_cyc + 1;
    if (req && bif.wbm_ack_i) n_ack <= n_ack + 1;
    if (mode == 0) begin
      ack_q <= req && !ack_q && ix >= 0;
      if (req && !ack_q && ix >= 0) begin
        sdat_q <= hmem[ix];
        if (bif.wbm_we_o)
          for (int b = 0; b < 4; b++)
            if (bif.wbm_sel_o[b])
              hmem[ix][8*b +: 8] <= bif.wbm_dat_o[8*b +: 8];
      end
    end else begin
      ack_q  <= req && (bcnt == dly - 1);
      sdat_q <= DLY_DATA;
    end
  end

  // reference model: the two harness registers
  logic [31:0] ref_mem [2] = '{32'h0, 32'h0};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // expected response of one command; updates the model
  task automatic ref_cmd(input logic we,
                         input logic [3:0] sel,
                         input logic [31:0] adr,
                         input logic [31:0] dat,
                         output logic [31:0] rd,
                         output logic er);
    int ix;
    ix = hidx(adr);
    er = (ix < 0);
    if (we) rd = '0;
    else if (ix < 0) rd = ERR;
    else rd = ref_mem[ix];
    if (we && ix >= 0)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[ix][8*b +: 8] = dat[8*b +: 8];
  endtask

  task automatic drive_cmd(input logic we,
                           input logic [3:0] sel,
                           input logic [31:0] adr,
                           input logic [31:0] dat);
    bif.cmd_valid = 1'b1;
    bif.cmd_we    = we;
    bif.cmd_sel   = sel;
    bif.cmd_addr  = adr;
    bif.cmd_wdata = dat;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bif.rsp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 300) chk("rsp_wait_expired", 32'(lat), 32'd0);
  endtask

  task automatic do_cmd(input logic we,
                        input logic [3:0] sel,
                        input logic [31:0] adr,
                        input logic [31:0] dat,
                        output logic [31:0] rd,
                        output logic er,
                        output int lat);
    drive_cmd(we, sel, adr, dat);
    chk("cmd_ready_idle", 32'(bif.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    wait_rsp(lat);
    rd = bif.rsp_rdata;
    er = bif.rsp_err;
    bif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bif.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd, hold_d;
    logic er, eer, hold_e;
    int lat, c0, a0, nrsp, acc, edges;
    logic fire_c, fire_r;
    logic [31:0] qd [$];
    logic qe [$];
    logic we;
    logic [3:0] sel;
    logic [31:0] adr, dat;

    bif.cmd_valid = 0; bif.cmd_we = 0; bif.cmd_sel = 0;
    bif.cmd_addr = 0; bif.cmd_wdata = 0; bif.rsp_ready = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(bif.wbm_cyc_o), 0);
    chk("rst_stb", 32'(bif.wbm_stb_o), 0);
    chk("rst_we", 32'(bif.wbm_we_o), 0);
    chk("rst_sel", 32'(bif.wbm_sel_o), 0);
    chk("rst_adr", bif.wbm_adr_o, 0);
    chk("rst_dat", bif.wbm_dat_o, 0);
    chk("rst_rsp_valid", 32'(bif.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bif.rsp_err), 0);
    chk("rst_rsp_rdata", bif.rsp_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", 32'(bif.cmd_ready), 1);

    // write ACTIVE then read back
    c0 = n_cyc; a0 = n_ack;
    ref_cmd(1, 4'hF, ADDR_ACTIVE, 32'h2, erd, eer);
    do_cmd(1, 4'hF, ADDR_ACTIVE, 32'h2, rd, er, lat);
    chk("wr_lat", 32'(lat), 2);
    chk("wr_err", 32'(er), 32'(eer));
    chk("wr_rdata", rd, erd);
    chk("wr_cyc_cycles", 32'(n_cyc - c0), 2);
    chk("wr_acks", 32'(n_ack - a0), 1);
    chk("wr_adr_held", bif.wbm_adr_o, ADDR_ACTIVE);
    chk("wr_cyc_low", 32'(bif.wbm_cyc_o), 0);
    ref_cmd(0, 4'hF, ADDR_ACTIVE, 0, erd, eer);
    do_cmd(0, 4'hF, ADDR_ACTIVE, 0, rd, er, lat);
    chk("rd_active", rd, erd);
    chk("rd_active_low", 32'(rd[7:0]), 32'h02);
    chk("rd_lat", 32'(lat), 2);

    // unmapped read and write time out
    c0 = n_cyc;
    do_cmd(0, 4'hF, UNMAPPED, 0, rd, er, lat);
    chk("to_cyc_cycles", 32'(n_cyc - c0), TO);
    chk("to_lat", 32'(lat), TO);
    chk("to_err", 32'(er), 1);
    chk("to_rdata", rd, ERR);
    do_cmd(1, 4'h3, UNMAPPED, 32'h55, rd, er, lat);
    chk("to_wr_err", 32'(er), 1);
    chk("to_wr_rdata", rd, 0);

    // ack on the exact expiry edge, then one edge too late
    mode = 1; dly = TO - 1;
    do_cmd(0, 4'hF, UNMAPPED, 0, rd, er, lat);
    chk("edge_ack_err", 32'(er), 0);
    chk("edge_ack_rdata", rd, DLY_DATA);
    chk("edge_ack_lat", 32'(lat), TO);
    dly = TO;
    a0 = n_ack;
    do_cmd(0, 4'hF, UNMAPPED, 0, rd, er, lat);
    chk("late_ack_err", 32'(er), 1);
    chk("late_ack_rdata", rd, ERR);
    repeat (2) @(posedge clk);
    #1;
    chk("late_ack_no_rsp", 32'(bif.rsp_valid), 0);
    chk("late_ack_no_hs", 32'(n_ack - a0), 0);
    mode = 0;

    // response held while rsp_ready low
    ref_cmd(1, 4'hF, ADDR_WS2812, 32'h00AA_55CC, erd, eer);
    drive_cmd(1, 4'hF, ADDR_WS2812, 32'h00AA_55CC);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    wait_rsp(lat);
    hold_d = bif.rsp_rdata;
    hold_e = bif.rsp_err;
    chk("hold_rdata0", hold_d, erd);
    chk("hold_err0", 32'(hold_e), 32'(eer));
    drive_cmd(0, 4'hF, ADDR_WS2812, 0);
    for (int i = 0; i < 10; i++) begin
      ack_force = (i == 4);
      @(posedge clk); #1;
      chk("hold_valid", 32'(bif.rsp_valid), 1);
      chk("hold_rdata", bif.rsp_rdata, hold_d);
      chk("hold_err", 32'(bif.rsp_err), 32'(hold_e));
      chk("hold_cmd_ready", 32'(bif.cmd_ready), 0);
      chk("hold_no_cyc", 32'(bif.wbm_cyc_o), 0);
    end
    ack_force = 1'b0;
    bif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bif.rsp_ready = 1'b0;
    chk("consume_valid", 32'(bif.rsp_valid), 0);
    chk("consume_no_cyc", 32'(bif.wbm_cyc_o), 0);
    chk("consume_ready", 32'(bif.cmd_ready), 1);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    chk("next_accept_cyc", 32'(bif.wbm_cyc_o), 1);
    ref_cmd(0, 4'hF, ADDR_WS2812, 0, erd, eer);
    wait_rsp(lat);
    chk("next_rdata", bif.rsp_rdata, erd);
    bif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bif.rsp_ready = 1'b0;

    // asynchronous reset while in BUS
    drive_cmd(0, 4'hF, UNMAPPED, 0);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(bif.wbm_cyc_o), 0);
    chk("arst_stb", 32'(bif.wbm_stb_o), 0);
    chk("arst_rsp_valid", 32'(bif.rsp_valid), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_cmd_ready", 32'(bif.cmd_ready), 1);
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_late_ack", 32'(bif.rsp_valid), 0);
    end

    // randomized single commands against the model
    for (int i = 0; i < 10; i++) begin
      int r;
      r = int'($urandom_range(0, 6));
      adr = (r < 3) ? ADDR_ACTIVE
          : (r < 6) ? ADDR_WS2812 : UNMAPPED;
      we  = 1'($urandom);
      sel = 4'($urandom);
      dat = $urandom;
      ref_cmd(we, sel, adr, dat, erd, eer);
      do_cmd(we, sel, adr, dat, rd, er, lat);
      chk("rnd_rdata", rd, erd);
      chk("rnd_err", 32'(er), 32'(eer));
      chk("rnd_lat", 32'(lat), eer ? TO : 2);
    end

    // back-to-back with rsp_ready tied high
    a0 = n_ack;
    nrsp = 0; acc = 0; edges = 0;
    bif.rsp_ready = 1'b1;
    we = 1'($urandom); sel = 4'($urandom); dat = $urandom;
    adr = $urandom_range(0, 1) ? ADDR_ACTIVE : ADDR_WS2812;
    ref_cmd(we, sel, adr, dat, erd, eer);
    qd.push_back(erd); qe.push_back(eer);
    drive_cmd(we, sel, adr, dat);
    while (nrsp < 6 && edges < 200) begin
      fire_c = bif.cmd_valid && bif.cmd_ready;
      fire_r = bif.rsp_valid && bif.rsp_ready;
      if (fire_r) begin
        chk("b2b_rdata", bif.rsp_rdata, qd.pop_front());
        chk("b2b_err", 32'(bif.rsp_err), 32'(qe.pop_front()));
        nrsp++;
      end
      @(posedge clk); #1;
      edges++;
      if (fire_c) begin
        acc++;
        if (acc < 6) begin
          we = 1'($urandom); sel = 4'($urandom);
          dat = $urandom;
          adr = $urandom_range(0, 1) ? ADDR_ACTIVE
                                     : ADDR_WS2812;
          ref_cmd(we, sel, adr, dat, erd, eer);
          qd.push_back(erd); qe.push_back(eer);
          drive_cmd(we, sel, adr, dat);
        end else begin
          bif.cmd_valid = 1'b0;
        end
      end
    end
    bif.rsp_ready = 1'b0;
    chk("b2b_responses", 32'(nrsp), 6);
    chk("b2b_accepts", 32'(acc), 6);
    chk("b2b_acks", 32'(n_ack - a0), 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
